// File: rtl/seg7_scroll_if.sv
// rtl/seg7_scroll_if.sv - switch/button inputs and anode/cathode/busy outputs of the scrolling display
interface seg7_scroll_if #(
    parameter int DATA_W = 16,
    parameter int NUM_AN = 4
) ();
    logic              start;
    logic              SL;
    logic              SR;
    logic [DATA_W-1:0] sw;
    logic [NUM_AN-1:0] AN;
    logic [6:0]        ledSEG;
    logic              busy;

    modport master (
        output start, SL, SR, sw,
        input  AN, ledSEG, busy
    );

    modport slave (
        input  start, SL, SR, sw,
        output AN, ledSEG, busy
    );
endinterface

// File: rtl/seg7_scroll_display.sv
// rtl/seg7_scroll_display.sv - sampled switch word to BCD via double-dabble, scanned onto a rotatable 7-seg window
// Optional feature macro: SIGNED_EN (two's-complement sample, sign shown as dash/blank).
module seg7_scroll_display #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIG    = 5,
    parameter int NUM_AN     = 4,
    parameter int SAMPLE_DIV = 100_000_000,
    parameter int SCAN_DIV   = 262_144
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scroll_if.slave       bus
);
    localparam int SMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int P_W   = (NUM_AN > 1) ? $clog2(NUM_AN) : 1;
    localparam int IT_W  = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * NUM_DIG;
    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [2:0]        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [2:0]        pulse;
    logic              start_p, sl_p, sr_p;

    logic              busy_q, busy_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  bcd_adj, bcd_shift;
    logic [DATA_W-1:0] magnitude;
    logic [3:0]        dig_q [NUM_DIG];
    logic [3:0]        dig_d [NUM_DIG];
`ifdef SIGNED_EN
    logic              sign_conv_q, sign_conv_d;
    logic              sign_q, sign_d;
`endif

    logic [SCN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [P_W-1:0]    p_q, p_d, p_next;
    logic [NUM_AN-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [6:0]        sign_glyph;
    logic [3:0]        sel_dig;

    assign bus.AN     = an_q;
    assign bus.ledSEG = seg_q;
    assign bus.busy   = busy_q;

    // Bit order {start, SL, SR}; edge detector fires once per press however long it is held.
    assign pulse   = sync2_q & ~prev_q;
    assign start_p = pulse[2];
    assign sl_p    = pulse[1];
    assign sr_p    = pulse[0];

`ifdef SIGNED_EN
    // Negating the most-negative value wraps to itself, which read unsigned is the right magnitude.
    assign magnitude  = sample_q[DATA_W-1] ? (~sample_q + DATA_W'(1)) : sample_q;
    assign sign_glyph = sign_q ? GLYPH_DASH : GLYPH_BLANK;
`else
    assign magnitude  = sample_q;
    assign sign_glyph = GLYPH_DASH;
`endif

    always_comb begin
        bcd_adj = '0;
        for (int n = 0; n < NUM_DIG; n++) begin
            bcd_adj[n*4 +: 4] = (bcd_q[n*4 +: 4] >= 4'd5) ? bcd_q[n*4 +: 4] + 4'd3 : bcd_q[n*4 +: 4];
        end
        bcd_shift = (bcd_adj << 1) | BCD_W'(shreg_q[DATA_W-1]);
    end

    always_comb begin
        smp_cnt_d = smp_cnt_q + SMP_W'(1);
        sample_d  = sample_q;
        if (smp_cnt_q == SMP_W'(SAMPLE_DIV - 1)) begin
            smp_cnt_d = '0;
            sample_d  = bus.sw;
        end

        sync1_d = {bus.start, bus.SL, bus.SR};
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        busy_d  = busy_q;
        iter_d  = iter_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        for (int i = 0; i < NUM_DIG; i++) dig_d[i] = dig_q[i];
`ifdef SIGNED_EN
        sign_conv_d = sign_conv_q;
        sign_d      = sign_q;
`endif

        if (busy_q) begin
            shreg_d = shreg_q << 1;
            bcd_d   = bcd_shift;
            iter_d  = iter_q + IT_W'(1);
            if (iter_q == IT_W'(DATA_W - 1)) begin
                busy_d = 1'b0;
                for (int i = 0; i < NUM_DIG; i++) dig_d[i] = bcd_shift[(NUM_DIG-1-i)*4 +: 4];
`ifdef SIGNED_EN
                sign_d = sign_conv_q;
`endif
            end
        end else if (start_p) begin
            busy_d  = 1'b1;
            iter_d  = '0;
            bcd_d   = '0;
            shreg_d = magnitude;
`ifdef SIGNED_EN
            sign_conv_d = sample_q[DATA_W-1];
`endif
        end else if (sl_p && !sr_p) begin
            for (int i = 0; i < NUM_DIG; i++) dig_d[i] = dig_q[(i + 1) % NUM_DIG];
        end else if (sr_p && !sl_p) begin
            for (int i = 0; i < NUM_DIG; i++) dig_d[i] = dig_q[(i + NUM_DIG - 1) % NUM_DIG];
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCN_W'(1);
        p_d        = p_q;
        an_d       = an_q;
        seg_d      = seg_q;
        p_next     = (p_q == P_W'(NUM_AN - 1)) ? '0 : p_q + P_W'(1);
        sel_dig    = '0;
        for (int k = 1; k < NUM_AN; k++) begin
            if (p_next == P_W'(k)) sel_dig = dig_q[k-1];
        end
        if (scan_cnt_q == SCN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            p_d        = p_next;
            an_d       = ~(NUM_AN'(1) << (NUM_AN - 1 - int'(p_next)));
            seg_d      = (p_next == '0) ? sign_glyph : glyph(sel_dig);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt_q  <= '0;
            sample_q   <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            busy_q     <= 1'b0;
            iter_q     <= '0;
            shreg_q    <= '0;
            bcd_q      <= '0;
            for (int i = 0; i < NUM_DIG; i++) dig_q[i] <= '0;
`ifdef SIGNED_EN
            sign_conv_q <= 1'b0;
            sign_q      <= 1'b0;
`endif
            scan_cnt_q <= '0;
            p_q        <= '0;
            an_q       <= '1;
            seg_q      <= GLYPH_BLANK;
        end else begin
            smp_cnt_q  <= smp_cnt_d;
            sample_q   <= sample_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            busy_q     <= busy_d;
            iter_q     <= iter_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            for (int i = 0; i < NUM_DIG; i++) dig_q[i] <= dig_d[i];
`ifdef SIGNED_EN
            sign_conv_q <= sign_conv_d;
            sign_q      <= sign_d;
`endif
            scan_cnt_q <= scan_cnt_d;
            p_q        <= p_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end
endmodule

// File: tb/tb_seg7_scroll_display.sv
// tb/tb_seg7_scroll_display.sv - directed and random checks of conversion, rotation and scan against a decimal model
module tb_seg7_scroll_display;
    localparam int DATA_W     = 16;
    localparam int NUM_DIG    = 5;
    localparam int NUM_AN     = 4;
    localparam int SAMPLE_DIV = 8;
    localparam int SCAN_DIV   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scroll_if #(.DATA_W(DATA_W), .NUM_AN(NUM_AN)) bus ();

    seg7_scroll_display #(
        .DATA_W(DATA_W), .NUM_DIG(NUM_DIG), .NUM_AN(NUM_AN),
        .SAMPLE_DIV(SAMPLE_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int ref_d [NUM_DIG];
    bit ref_neg = 1'b0;

    function automatic logic [6:0] glyph_of(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] sign_glyph_ref();
`ifdef SIGNED_EN
        return ref_neg ? 7'b1111110 : 7'b1111111;
`else
        return 7'b1111110;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_load(input logic [DATA_W-1:0] v);
        int mag;
        mag     = int'(v);
        ref_neg = 1'b0;
`ifdef SIGNED_EN
        if (v[DATA_W-1]) begin
            mag     = (1 << DATA_W) - int'(v);
            ref_neg = 1'b1;
        end
`endif
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            ref_d[i] = mag % 10;
            mag      = mag / 10;
        end
    endtask

    task automatic model_rot(input bit left);
        int tmp [NUM_DIG];
        for (int i = 0; i < NUM_DIG; i++) tmp[i] = ref_d[i];
        for (int i = 0; i < NUM_DIG; i++)
            ref_d[i] = left ? tmp[(i + 1) % NUM_DIG] : tmp[(i + NUM_DIG - 1) % NUM_DIG];
    endtask

    task automatic press(input bit s, input bit l, input bit r);
        bus.start = s; bus.SL = l; bus.SR = r;
        clk_n(6);
        bus.start = 0; bus.SL = 0; bus.SR = 0;
        clk_n(4);
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < NUM_DIG; i++) chk(tag, 32'(dut.dig_q[i]), 32'(ref_d[i]));
    endtask

    task automatic check_window(input string tag);
        logic [NUM_AN-1:0] pat;
        int t;
        for (int k = 0; k < NUM_AN; k++) begin
            pat = ~(NUM_AN'(1) << (NUM_AN - 1 - k));
            t = 0;
            while (bus.AN !== pat && t < 4 * NUM_AN * SCAN_DIV + 4) begin
                clk_n(1);
                t++;
            end
            chk({tag, "_an"}, 32'(bus.AN), 32'(pat));
            chk({tag, "_seg"}, 32'(bus.ledSEG),
                32'((k == 0) ? sign_glyph_ref() : glyph_of(ref_d[k-1])));
        end
    endtask

    task automatic wait_busy(input bit lvl, input int bound, output int cycles);
        cycles = 0;
        while (bus.busy !== lvl && cycles < bound) begin
            clk_n(1);
            cycles++;
        end
    endtask

    task automatic convert(input logic [DATA_W-1:0] v);
        int c;
        bus.sw = v;
        clk_n(2 * SAMPLE_DIV + 2);
        bus.start = 1'b1;
        wait_busy(1'b1, 20, c);
        chk("busy_rise", 32'(bus.busy), 32'd1);
        wait_busy(1'b0, 100, c);
        chk("busy_len", 32'(c), 32'(DATA_W));
        bus.start = 1'b0;
        clk_n(4);
        model_load(v);
    endtask

    initial begin
        int c;
        int nrot;
        bit dir;
        logic [DATA_W-1:0] v;

        rst = 1'b1;
        bus.start = 0; bus.SL = 0; bus.SR = 0; bus.sw = '0;
        for (int i = 0; i < NUM_DIG; i++) ref_d[i] = 0;
        clk_n(3);
        chk("rst_an", 32'(bus.AN), 32'hF);
        chk("rst_seg", 32'(bus.ledSEG), 32'h7F);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        check_buf("rst_buf");
        rst = 1'b0;
        clk_n(1);
        chk("blank_after_rst", 32'(bus.AN), 32'hF);

        convert(DATA_W'(12345));
        check_buf("load_12345");
        check_window("win_12345");

        press(0, 1, 0); model_rot(1'b1);
        check_buf("sl1");
        check_window("win_sl1");
        for (int i = 0; i < 4; i++) begin press(0, 1, 0); model_rot(1'b1); end
        check_buf("sl5");
        press(0, 0, 1); model_rot(1'b0);
        check_buf("sr1");
        check_window("win_sr1");

        press(0, 1, 1);
        check_buf("sl_sr_same");

        bus.start = 1'b1;
        clk_n(3);
        bus.SL = 1'b1;
        clk_n(6);
        bus.SL = 1'b0;
        wait_busy(1'b0, 100, c);
        bus.start = 1'b0;
        clk_n(4);
        model_load(bus.sw);
        check_buf("sl_while_busy");

        convert(16'hFFFF);
        check_buf("load_ffff");
        check_window("win_ffff");
        convert(16'h8000);
        check_buf("load_8000");
        check_window("win_8000");

        for (int it = 0; it < 8; it++) begin
            v = DATA_W'($urandom);
            convert(v);
            check_buf("rnd_load");
            nrot = $urandom_range(1, 4);
            for (int r = 0; r < nrot; r++) begin
                dir = 1'($urandom_range(0, 1));
                press(0, dir, !dir);
                model_rot(dir);
            end
            check_buf("rnd_rot");
            check_window("rnd_win");
        end

        bus.sw = DATA_W'(12345);
        clk_n(2 * SAMPLE_DIV + 2);
        bus.start = 1'b1;
        wait_busy(1'b1, 20, c);
        clk_n(5);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_an", 32'(bus.AN), 32'hF);
        chk("midrst_seg", 32'(bus.ledSEG), 32'h7F);
        for (int i = 0; i < NUM_DIG; i++) ref_d[i] = 0;
        ref_neg = 1'b0;
        check_buf("midrst_buf");
        bus.start = 1'b0;
        clk_n(2);
        rst = 1'b0;
        clk_n(2);
        check_buf("post_rst_buf");
        convert(DATA_W'(54321));
        check_buf("post_rst_load");
        check_window("post_rst_win");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
